uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised UART receiver; next generation of the fixed 8-bit receive FSM.
- Generates its own oversampling tick from sys_clk through a runtime divisor, so no external slow clock is needed.
- Configurable data width, parity and stop bits; 3-sample majority vote per bit.
- Per-word frame/parity error flags and a small output FIFO with valid/ready handshake. Sits between the RX pin and the consumer logic.

Parameters:
- DATA_BITS, 8, data bits per frame, legal 5..9.
- PARITY, 0, 0 none / 1 odd / 2 even.
- STOP_BITS, 1, stop bits checked, 1 or 2.
- OVERSAMPLE, 16, ticks per bit, power of two, 8..16.
- DIV_W, 16, width of baud_div.
- FIFO_DEPTH, 4, output FIFO entries, power of two, >=2.

Ports:
- sys_clk  in  1  single clock for the whole block.
- rst  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_W  sys_clk cycles per oversample tick; 0 is treated as 1.
- RX  in  1  asynchronous serial input; idle high.
- clr_err  in  1  one-cycle pulse; clears overrun.
- data_ready  in  1  consumer accepts head word.
- data_out  out  DATA_BITS  head word data, LSB = first received bit.
- data_valid  out  1  FIFO non-empty.
- frame_error  out  1  head word had a low stop bit; 0 when empty.
- parity_error  out  1  head word failed parity; 0 when empty; always 0 if PARITY=0.
- overrun  out  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, async)
  - Outputs 0; FIFO empty; state IDLE; counters 0.
  - 2-flop RX synchroniser resets to 1.
  - Reset asserted mid-frame discards the partial frame.
- Tick generator: counter 0..max(baud_div,1)-1; one-cycle tick on the terminal count. Free-running.
- Sampling: bit-phase counter s = 0..OVERSAMPLE-1, advanced on each tick.
  - Samples taken at s = H-1, H, H+1, where H = OVERSAMPLE/2.
  - Majority vote resolved at s = H+1.
- States: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
  - IDLE: on a tick with synced RX=0, go to START with s=1.
  - START: vote=1 -> IDLE (false start, no word, no flag). Else, at s=OVERSAMPLE-1 -> DATA.
  - DATA: shift the vote in LSB-first. After DATA_BITS bits -> PAR if PARITY!=0, else STOP.
  - PAR: compare the vote against the odd/even parity of the data bits; a mismatch sets pe.
  - STOP: any stop vote of 0 sets fe. Decision taken at the midpoint of the last stop bit (no wait for bit end).
    - Push {pe, fe, data}.
    - fe=0 -> IDLE; fe=1 -> WAIT_HIGH.
  - WAIT_HIGH: remain until synced RX=1, then IDLE. A break condition produces exactly one word, with fe=1 and data=0.
- FIFO
  - Show-ahead: data_valid rises the cycle after the push.
  - Pop when data_valid && data_ready.
  - Push while full and no pop: word dropped, overrun=1.
  - Push and pop in the same cycle while full: both accepted, no overrun.
  - Pop while empty is ignored.
  - Order is strictly FIFO; pointers wrap modulo FIFO_DEPTH.
- overrun: cleared by clr_err. If a clr_err and an overrun event coincide, set wins.
- Latency: RX edge to synchroniser output is 2 cycles. Last stop-bit midpoint vote to data_valid is 1 cycle.

Decomposition:
- Package uart_pkg holds:
  - State enum.
  - Parity encodings PAR_NONE/PAR_ODD/PAR_EVEN.
  - Function computing the parity bit for a given mode.
- Sub-module uart_rx_fifo: parametrised width DATA_BITS+2 and depth FIFO_DEPTH; push/pop/full/empty.
- Tick generator, synchroniser and FSM stay in uart_rx_param.

Test Plan:
- 8N1, baud_div=4, OVERSAMPLE=16 (64 clk/bit). Send 0xA5 -> data_out=0xA5, fe=0, pe=0, data_valid 1 cycle after the stop midpoint.
- PARITY=2, send 0x3C with parity bit 1 -> data_out=0x3C, parity_error=1. Same frame with parity 0 -> parity_error=0.
- Stop bit driven 0, then RX held low 200 cycles -> exactly one word with frame_error=1. Next valid frame 0x55 is received correctly.
- RX low pulse of 16 clk (quarter bit) -> no word, data_valid stays 0, state returns to IDLE.
- FIFO_DEPTH=4, data_ready=0, send 0x01..0x05 -> overrun=1; pop order 0x01,0x02,0x03,0x04, then data_valid=0. clr_err -> overrun=0.
- rst low mid-DATA of 0xFF, release, send 0x81 -> only 0x81 emerges. DATA_BITS=7 variant: 0x7F -> 0x7F.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, parity modes and parity helper.
// Imported by uart_rx_param and uart_rx_fifo.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  // Parity bit a transmitter appends to d (zero-extended) for the mode.
  function automatic logic par_bit(
    input logic [1:0] mode,
    input logic [8:0] d
  );
    if (mode == PAR_EVEN) return ^d;
    if (mode == PAR_ODD) return ~^d;
    return 1'b0;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead FIFO, W bits x DEPTH words.
// Ports: clk, rst_n, push/din, pop, dout (0 when empty), full, empty.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_pop;
  logic         do_push;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);

  // A pop frees the slot, so a push while full is still taken.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

  assign dout = empty ? '0 : mem[rp[AW-1:0]];

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote and FIFO.
// Ports: sys_clk, rst(n), baud_div, RX, clr_err, data_ready -> data/flags.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic                 RX,
  input  logic                 clr_err,
  input  logic                 data_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 overrun
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int H  = OVERSAMPLE / 2;
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;

  localparam logic [SW-1:0] S_A   = SW'(H - 1);
  localparam logic [SW-1:0] S_B   = SW'(H);
  localparam logic [SW-1:0] S_V   = SW'(H + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);
  localparam logic [1:0]    PMODE = 2'(PARITY);
  localparam logic          SC_END = 1'(STOP_BITS - 1);

  logic [DIV_W-1:0] tcnt;
  logic [DIV_W-1:0] tlim;
  logic             tick;

  assign tlim = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
  assign tick = (tcnt >= tlim);

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) tcnt <= '0;
    else      tcnt <= tick ? '0 : tcnt + 1'b1;
  end

  logic [1:0] rx_q;
  logic       rx_s;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) rx_q <= 2'b11;
    else      rx_q <= {rx_q[0], RX};
  end

  assign rx_s = rx_q[1];

  rx_state_e          state, state_n;
  logic [SW-1:0]      s, s_n;
  logic [BW-1:0]      bcnt, bcnt_n;
  logic [DATA_BITS-1:0] sh, sh_n;
  logic               pe, pe_n;
  logic               fe, fe_n;
  logic               sc, sc_n;
  logic [1:0]         smp, smp_n;
  logic               vote;
  logic               mid;
  logic               last;
  logic               fe_w;
  logic               push;

  // Third sample is the live one, so the vote resolves at s = H+1.
  assign vote = (smp[0] & smp[1]) |
                (smp[0] & rx_s) |
                (smp[1] & rx_s);
  assign mid  = (s == S_V);
  assign last = (s == S_END);
  assign fe_w = fe | ~vote;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s     <= '0;
      bcnt  <= '0;
      sh    <= '0;
      pe    <= 1'b0;
      fe    <= 1'b0;
      sc    <= 1'b0;
      smp   <= 2'b11;
    end else begin
      state <= state_n;
      s     <= s_n;
      bcnt  <= bcnt_n;
      sh    <= sh_n;
      pe    <= pe_n;
      fe    <= fe_n;
      sc    <= sc_n;
      smp   <= smp_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    bcnt_n  = bcnt;
    sh_n    = sh;
    pe_n    = pe;
    fe_n    = fe;
    sc_n    = sc;
    smp_n   = smp;
    push    = 1'b0;
    if (tick && (state inside {START, DATA, PAR, STOP})) begin
      s_n = s + 1'b1;
      if (s == S_A) smp_n[0] = rx_s;
      if (s == S_B) smp_n[1] = rx_s;
    end
    unique case (state)
      IDLE: begin
        if (tick && !rx_s) begin
          state_n = START;
          s_n     = SW'(1);
          bcnt_n  = '0;
          pe_n    = 1'b0;
          fe_n    = 1'b0;
          sc_n    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (mid && vote) state_n = IDLE;
          else if (last)   state_n = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (mid) sh_n = {vote, sh[DATA_BITS-1:1]};
          if (last) begin
            bcnt_n = bcnt + 1'b1;
            if (bcnt == B_END)
              state_n = (PMODE != PAR_NONE) ? PAR : STOP;
          end
        end
      end
      PAR: begin
        if (tick) begin
          if (mid)  pe_n = vote != par_bit(PMODE, 9'(sh));
          if (last) state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          if (mid) begin
            fe_n = fe_w;
            if (sc == SC_END) begin
              push    = 1'b1;
              state_n = fe_w ? WAIT_HIGH : IDLE;
            end
          end
          if (last) sc_n = 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [FW-1:0] head;
  logic          full;
  logic          empty;
  logic          pop;

  assign data_valid = !empty;
  assign pop        = data_valid && data_ready;

  uart_rx_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst),
    .push  (push),
    .din   ({pe, fe_w, sh}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign {parity_error, frame_error, data_out} = head;

  // Set wins over a coincident clear.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst)                    overrun <= 1'b0;
    else if (push && full && !pop) overrun <= 1'b1;
    else if (clr_err)            overrun <= 1'b0;
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed bench for three receiver configurations.
// A = 8N1, B = 8E1, C = 7N1; baud_div = 4, 64 clocks per bit.
module tb_uart_rx_param;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [2:0]  rxv     = 3'b111;
  logic        clr_err = 1'b0;
  logic [2:0]  rdy     = 3'b000;

  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic dv_a, dv_b, dv_c;
  logic fe_a, fe_b, fe_c;
  logic pe_a, pe_b, pe_c;
  logic ov_a, ov_b, ov_c;
  wire logic [2:0] dv = {dv_c, dv_b, dv_a};

  uart_rx_param u_a (
    .sys_clk(sys_clk), .rst(rst), .baud_div(baud_div),
    .RX(rxv[0]), .clr_err(clr_err), .data_ready(rdy[0]),
    .data_out(d_a), .data_valid(dv_a), .frame_error(fe_a),
    .parity_error(pe_a), .overrun(ov_a)
  );

  uart_rx_param #(.PARITY(2)) u_b (
    .sys_clk(sys_clk), .rst(rst), .baud_div(baud_div),
    .RX(rxv[1]), .clr_err(clr_err), .data_ready(rdy[1]),
    .data_out(d_b), .data_valid(dv_b), .frame_error(fe_b),
    .parity_error(pe_b), .overrun(ov_b)
  );

  uart_rx_param #(.DATA_BITS(7)) u_c (
    .sys_clk(sys_clk), .rst(rst), .baud_div(baud_div),
    .RX(rxv[2]), .clr_err(clr_err), .data_ready(rdy[2]),
    .data_out(d_c), .data_valid(dv_c), .frame_error(fe_c),
    .parity_error(pe_c), .overrun(ov_c)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int last_rise [3] = '{0, 0, 0};
  int rcnt [3] = '{0, 0, 0};
  logic [2:0] dvp = 3'b000;

  always @(negedge sys_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (dv[i] && !dvp[i]) begin
        last_rise[i] = cyc;
        rcnt[i] = rcnt[i] + 1;
      end
    end
    dvp = dv;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic int h_d(input int w);
    if (w == 0) return int'(d_a);
    if (w == 1) return int'(d_b);
    return int'(d_c);
  endfunction

  function automatic int h_fe(input int w);
    if (w == 0) return int'(fe_a);
    if (w == 1) return int'(fe_b);
    return int'(fe_c);
  endfunction

  function automatic int h_pe(input int w);
    if (w == 0) return int'(pe_a);
    if (w == 1) return int'(pe_b);
    return int'(pe_c);
  endfunction

  task automatic drive(input int w, input logic v, input int n);
    rxv[w] = v;
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Stop-bit index within the frame for each instance.
  function automatic int stop_idx(input int w);
    if (w == 1) return 10;
    if (w == 2) return 8;
    return 9;
  endfunction

  task automatic send(input int w, input logic [8:0] d,
                      input logic pb, input logic stopv,
                      output int t0);
    int db;
    db = (w == 2) ? 7 : 8;
    t0 = cyc;
    drive(w, 1'b0, 64);
    for (int i = 0; i < db; i++) drive(w, d[i], 64);
    if (w == 1) drive(w, pb, 64);
    drive(w, stopv, 64);
    rxv[w] = 1'b1;
  endtask

  task automatic pop(input int w);
    rdy[w] = 1'b1;
    @(posedge sys_clk);
    #1;
    rdy[w] = 1'b0;
  endtask

  // Receive one good word and check it against hand-computed values.
  task automatic rx_word(input string nm, input int w,
                         input logic [8:0] d, input logic pb,
                         input int exp_d, input int exp_pe);
    int t0;
    int c0;
    int lo;
    c0 = rcnt[w];
    send(w, d, pb, 1'b1, t0);
    drive(w, 1'b1, 8);
    lo = 64 * stop_idx(w) + 39;
    chk({nm, "_cnt"}, rcnt[w] - c0, 1);
    chk_rng({nm, "_lat"}, last_rise[w] - t0, lo, lo + 3);
    chk({nm, "_valid"}, int'(dv[w]), 1);
    chk({nm, "_data"}, h_d(w), exp_d);
    chk({nm, "_fe"}, h_fe(w), 0);
    chk({nm, "_pe"}, h_pe(w), exp_pe);
    pop(w);
    chk({nm, "_empty"}, int'(dv[w]), 0);
  endtask

  typedef struct {
    string      nm;
    int         w;
    logic [8:0] d;
    logic       pb;
    int         exp_d;
    int         exp_pe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int t0;
    int c0;

    vecs[0] = '{"a_a5",   0, 9'h0A5, 1'b0, 'hA5, 0};
    vecs[1] = '{"b_3c_p1", 1, 9'h03C, 1'b1, 'h3C, 1};
    vecs[2] = '{"b_3c_p0", 1, 9'h03C, 1'b0, 'h3C, 0};
    vecs[3] = '{"c_7f",   2, 9'h07F, 1'b0, 'h7F, 0};
    vecs[4] = '{"a_00",   0, 9'h000, 1'b0, 'h00, 0};
    vecs[5] = '{"b_01_p1", 1, 9'h001, 1'b1, 'h01, 0};
    vecs[6] = '{"b_07_p0", 1, 9'h007, 1'b0, 'h07, 1};
    vecs[7] = '{"a_ff",   0, 9'h0FF, 1'b0, 'hFF, 0};
    vecs[8] = '{"c_2a",   2, 9'h02A, 1'b0, 'h2A, 0};

    repeat (5) @(posedge sys_clk);
    #1;
    chk("rst_valid", int'(dv_a), 0);
    chk("rst_data", int'(d_a), 0);
    chk("rst_fe", int'(fe_a), 0);
    chk("rst_pe", int'(pe_a), 0);
    chk("rst_ovr", int'(ov_a), 0);
    rst = 1'b1;
    drive(0, 1'b1, 20);

    for (int i = 0; i < 9; i++)
      rx_word(vecs[i].nm, vecs[i].w, vecs[i].d, vecs[i].pb,
              vecs[i].exp_d, vecs[i].exp_pe);

    c0 = rcnt[0];
    drive(0, 1'b0, 16);
    drive(0, 1'b1, 200);
    chk("glitch_cnt", rcnt[0] - c0, 0);
    chk("glitch_valid", int'(dv_a), 0);
    rx_word("after_glitch", 0, 9'h03C, 1'b0, 'h3C, 0);

    c0 = rcnt[0];
    send(0, 9'h000, 1'b0, 1'b0, t0);
    drive(0, 1'b0, 200);
    drive(0, 1'b1, 100);
    chk("brk_cnt", rcnt[0] - c0, 1);
    chk("brk_valid", int'(dv_a), 1);
    chk("brk_data", int'(d_a), 0);
    chk("brk_fe", int'(fe_a), 1);
    pop(0);
    chk("brk_empty", int'(dv_a), 0);
    rx_word("after_brk", 0, 9'h055, 1'b0, 'h55, 0);

    for (int k = 1; k <= 5; k++) begin
      send(0, 9'(k), 1'b0, 1'b1, t0);
      drive(0, 1'b1, 40);
      if (k == 4) chk("ovr_before", int'(ov_a), 0);
    end
    chk("ovr_set", int'(ov_a), 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovr_pop%0d", k), int'(d_a), k);
      pop(0);
    end
    chk("ovr_empty", int'(dv_a), 0);
    chk("ovr_sticky", int'(ov_a), 1);
    clr_err = 1'b1;
    @(posedge sys_clk);
    #1;
    clr_err = 1'b0;
    chk("ovr_clr", int'(ov_a), 0);

    drive(0, 1'b0, 64);
    drive(0, 1'b1, 64 * 3 + 20);
    rst = 1'b0;
    drive(0, 1'b1, 5);
    chk("mid_rst_valid", int'(dv_a), 0);
    rst = 1'b1;
    c0 = rcnt[0];
    drive(0, 1'b1, 700);
    chk("mid_rst_none", rcnt[0] - c0, 0);
    rx_word("after_rst", 0, 9'h081, 1'b0, 'h81, 0);
    rx_word("c_after_rst", 2, 9'h07F, 1'b0, 'h7F, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
